// File: rtl/vga_pkg.sv
// Shared raster timing constants for the VGA output path.
// Defaults describe 640x480 at ~60 Hz on a 25.125 MHz pixel clock.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int sync_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = sync_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = sync_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Registered raster outputs of the timing generator, consumed by the
// frame-buffer reader and the VGA connector.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic               hsync_o;
    logic               vsync_o;
    logic               de_o;
    logic [COORD_W-1:0] x_o;
    logic [COORD_W-1:0] y_o;
    logic               line_start_o;
    logic               frame_start_o;

    modport master (
        output hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o
    );

    modport slave (
        input hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o
    );

endinterface

// File: rtl/sync_counter.sv
// One raster axis: counts 0..TOTAL-1 on each advance strobe and decodes
// the active and sync regions of the current count.
module sync_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv,
    input  logic               clr,
    output logic [COORD_W-1:0] cnt,
    output logic               wrap,
    output logic               in_active,
    output logic               in_sync
);

    localparam int TOTAL    = sync_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_BEG = ACTIVE + FP;
    localparam int SYNC_END = ACTIVE + FP + SYNC;
    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

    if (TOTAL > (1 << COORD_W)) begin : g_total_check
        $error("sync_counter: total of %0d does not fit the coordinate width", TOTAL);
    end

    // clr has priority so a disable landing on a wrap still returns to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    assign wrap      = (cnt == LAST);
    assign in_active = (int'(cnt) < ACTIVE);
    assign in_sync   = (int'(cnt) >= SYNC_BEG) && (int'(cnt) < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters plus one
// register stage that turns counter state into sync, DE and coordinates.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    vga_timing_gen_if.master  vga
);

    localparam logic SYNC_IDLE = !SYNC_POL;

    logic [COORD_W-1:0] h_cnt_p0, v_cnt_p0;
    logic               h_wrap_p0, v_wrap_unused;
    logic               h_act_p0, v_act_p0, h_sync_p0, v_sync_p0;
    logic               de_p0, line_start_p0, frame_start_p0;

    sync_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
    ) u_h_counter (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .adv       (en_i),
        .clr       (!en_i),
        .cnt       (h_cnt_p0),
        .wrap      (h_wrap_p0),
        .in_active (h_act_p0),
        .in_sync   (h_sync_p0)
    );

    sync_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
    ) u_v_counter (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .adv       (en_i && h_wrap_p0),
        .clr       (!en_i),
        .cnt       (v_cnt_p0),
        .wrap      (v_wrap_unused),
        .in_active (v_act_p0),
        .in_sync   (v_sync_p0)
    );

    assign de_p0          = h_act_p0 && v_act_p0;
    assign line_start_p0  = (h_cnt_p0 == '0);
    assign frame_start_p0 = line_start_p0 && (v_cnt_p0 == '0);

    // p0 -> p1: every output registered from the same counter state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vga.hsync_o       <= SYNC_IDLE;
            vga.vsync_o       <= SYNC_IDLE;
            vga.de_o          <= 1'b0;
            vga.x_o           <= '0;
            vga.y_o           <= '0;
            vga.line_start_o  <= 1'b0;
            vga.frame_start_o <= 1'b0;
        end else if (!en_i) begin
            vga.hsync_o       <= SYNC_IDLE;
            vga.vsync_o       <= SYNC_IDLE;
            vga.de_o          <= 1'b0;
            vga.x_o           <= '0;
            vga.y_o           <= '0;
            vga.line_start_o  <= 1'b0;
            vga.frame_start_o <= 1'b0;
        end else begin
            vga.hsync_o       <= h_sync_p0 ? SYNC_POL : SYNC_IDLE;
            vga.vsync_o       <= v_sync_p0 ? SYNC_POL : SYNC_IDLE;
            vga.de_o          <= de_p0;
            vga.x_o           <= de_p0 ? h_cnt_p0 : '0;
            vga.y_o           <= de_p0 ? v_cnt_p0 : '0;
            vga.line_start_o  <= line_start_p0;
            vga.frame_start_o <= frame_start_p0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so whole
// frames, wraps, enable drops and asynchronous resets fit in a short run.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int   HA = 16, HF = 4, HS = 6, HB = 5;
    localparam int   VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam logic POL = 1'b0;

    typedef struct packed {
        logic         hs;
        logic         vs;
        logic         de;
        logic [9:0]   x;
        logic [9:0]   y;
        logic         ls;
        logic         fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   pix = 0;
    int   cyc = 0;
    bit   started = 1'b0;

    vga_timing_gen_if vga ();

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (POL)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .vga     (vga)
    );

    always #5 clk = ~clk;

    function automatic exp_t idle_val();
        exp_t e;
        e.hs = !POL;
        e.vs = !POL;
        e.de = 1'b0;
        e.x  = '0;
        e.y  = '0;
        e.ls = 1'b0;
        e.fs = 1'b0;
        return e;
    endfunction

    // Expected outputs for the k-th enabled pixel since the raster started
    function automatic exp_t ref_at(int k);
        exp_t e;
        int h, v;
        h = k % HT;
        v = (k / HT) % VT;
        e.hs = (h >= HA + HF && h < HA + HF + HS) ? POL : !POL;
        e.vs = (v >= VA + VF && v < VA + VF + VS) ? POL : !POL;
        e.de = (h < HA) && (v < VA);
        e.x  = e.de ? 10'(h) : 10'd0;
        e.y  = e.de ? 10'(v) : 10'd0;
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.hs = vga.hsync_o;
        a.vs = vga.vsync_o;
        a.de = vga.de_o;
        a.x  = vga.x_o;
        a.y  = vga.y_o;
        a.ls = vga.line_start_o;
        a.fs = vga.frame_start_o;
        return a;
    endfunction

    task automatic compare(string name, exp_t a, exp_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b need hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                     name, cyc, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs,
                     e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs);
        end
    endtask

    // Reference model: one expectation per clock edge
    always @(posedge clk) begin
        cyc++;
        if (!rst_n || !en) begin
            q.push_back(idle_val());
            pix = 0;
        end else begin
            q.push_back(ref_at(pix));
            pix++;
        end
        started = 1'b1;
    end

    // Monitor: outputs are stable mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() == 0) begin
            if (started) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty cyc=%0d got size=0 need size>0", cyc);
            end
        end else begin
            e = q.pop_front();
            if (!rst_n) e = idle_val();
            compare("raster", actual(), e);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got timeout need finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Two full frames plus a little, covering every wrap
        #2 en = 1'b1;
        repeat (2 * HT * VT + 40) @(posedge clk);

        // Short mid-line disable
        #2 en = 1'b0;
        repeat (5) @(posedge clk);
        #2 en = 1'b1;

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(1, (3 * HT * VT) / 4)) @(posedge clk);
            #2 en = 1'b0;
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #2 en = 1'b1;
        end

        // Asynchronous resets mid-frame, checked before the next edge
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(HT + 1, HT * VT)) @(posedge clk);
            #2 rst_n = 1'b0;
            #1 compare("async_reset", actual(), idle_val());
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2 rst_n = 1'b1;
        end
        repeat (HT * VT + HT) @(posedge clk);

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the VGA output path. It runs on the 25.125 MHz pixel clock from the on-chip PLL and produces 640x480 @ ~60 Hz sync, data-enable and pixel coordinates. The frame-buffer reader uses these signals to fetch pixels, and they also drive the VGA connector. The PLL lock indication drives `en_i`, so no raster is emitted until the pixel clock is stable.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- `clk_i` in 1: pixel clock (25.125 MHz, PLL global output)
- `rst_n_i` in 1: reset, asynchronous assert, active-low
- `en_i` in 1: run enable (PLL lock); low holds the raster at origin
- `hsync_o` out 1: horizontal sync
- `vsync_o` out 1: vertical sync
- `de_o` out 1: pixel in active area
- `x_o` out 10: active-area column, 0..H_ACTIVE-1; 0 outside active area
- `y_o` out 10: active-area row, 0..V_ACTIVE-1; 0 outside active area
- `line_start_o` out 1: one-cycle pulse at h=0 of every line
- `frame_start_o` out 1: one-cycle pulse at (h=0, v=0)

## Operation
- Internal counters:
  - `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - `v_cnt` counts 0..V_TOTAL-1, where V_TOTAL = 525.
  - Both counters are 10-bit. Totals must be ≤1024; this is checked at elaboration.
- Horizontal counter: `h_cnt` increments every enabled cycle. At H_TOTAL-1 it wraps to 0 and `v_cnt` advances.
- Vertical counter: `v_cnt` wraps from V_TOTAL-1 to 0 in the same cycle `h_cnt` wraps.
- Line regions, by `h_cnt`:
  - active: [0, H_ACTIVE)
  - front porch: [H_ACTIVE, H_ACTIVE+H_FP)
  - sync: [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - back porch: the remainder
- Frame regions: same scheme on `v_cnt` using the V_* parameters.
- hsync_o = SYNC_POL while `h_cnt` is in the sync region, otherwise ~SYNC_POL. vsync_o follows the same rule on `v_cnt`.
- vsync timing: vsync transitions only at `h_cnt` = 0 boundaries. It asserts for exactly V_SYNC full lines.
- de_o = (h active) AND (v active). When de_o=1, x_o = h_cnt and y_o = v_cnt; otherwise both are 0.
- line_start_o fires at h_cnt=0 on every line, including blanking lines. frame_start_o fires only when v_cnt is also 0.
- en_i low:
  - counters are cleared to 0 on the next edge;
  - all outputs go to their reset values;
  - a later en_i rise restarts the raster from pixel (0,0).
- Reset (asynchronous, any time, including mid-line): counters are 0 and outputs take their reset values immediately.
- Reset values:
  - hsync_o = vsync_o = ~SYNC_POL
  - de_o = 0, x_o = 0, y_o = 0
  - line_start_o = 0, frame_start_o = 0

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Latency: outputs describe the counter state of the previous cycle, a fixed 1-clock latency that is identical for all outputs. The sync/de/coordinate alignment is therefore exact.
- The first edge with en_i=1 after reset/disable is counter state (0,0). frame_start_o, line_start_o and de_o=1 with x_o=y_o=0 appear together on the following cycle.
- Period checks:
  - line period: exactly H_TOTAL clocks (800)
  - frame period: exactly H_TOTAL*V_TOTAL clocks (420000, ≈59.82 Hz at 25.125 MHz)
- Pulse widths:
  - hsync asserted for H_SYNC consecutive clocks per line
  - de_o high for H_ACTIVE consecutive clocks on each of V_ACTIVE lines
- Simultaneous h-wrap and v-wrap at (799,524) are handled in one cycle. The next state is (0,0) and frame_start_o pulses.
- en_i dropping in the same cycle as a wrap: disable wins, and counters go to 0.

## Structure
- Shared package `vga_pkg`:
  - default 640x480 timing constants
  - H_TOTAL / V_TOTAL derivation
  - coordinate width constant (10)
- One natural sub-module, `sync_counter`, instantiated twice (horizontal and vertical):
  - parameterized by active/fp/sync/bp
  - inputs: advance strobe, clear
  - outputs: count, wrap, in_active, in_sync
- Top-level registers the combined outputs.

## Test plan
- Reset then en_i=1: the cycle after the first enabled edge shows frame_start_o=1, line_start_o=1, de_o=1, x_o=0, y_o=0.
- Horizontal timing: count de_o high for 640 clocks, low for 160. hsync low exactly 96 clocks, beginning 16 clocks after de_o falls. line_start_o period is 800.
- Vertical timing: de_o active on lines 0..479. vsync low for lines 490..491 (2×800 clocks) and aligned to line_start_o. frame_start_o period is 420000.
- Coordinates: at the last active pixel, x_o=639, y_o=479. Next cycle de_o=0, x_o=0, y_o=0. Wrap from (799,524) to (0,0) with frame_start_o pulse.
- en_i toggled low mid-line (e.g. at h=300, v=100) for 5 cycles, then high: outputs go idle one cycle after the drop. The raster restarts at (0,0) with frame_start_o.
- rst_n_i asserted asynchronously mid-frame: outputs take reset values without waiting for a clock edge. After release with en_i=1, the raster restarts at (0,0).
